// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: per-key synchroniser, debounce,
// press/release pulses, toggle state and long-press detection.

module key_debounce_multi_lane #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel,
    output logic toggle,
    output logic lng,
    output logic held
);
    localparam int   DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int   HW   = $clog2(LONG_CYCLES);
    localparam logic IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);

    logic [1:0]    sync;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          s;
    logic          accept;

    // XOR with the idle level maps the synchronised pin to 1 = pressed
    assign s      = sync[1] ^ IDLE;
    assign accept = (s != level) && (dcnt == DMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= {2{IDLE}};
            dcnt   <= '0;
            hcnt   <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
            toggle <= 1'b0;
            lng    <= 1'b0;
            held   <= 1'b0;
        end else begin
            sync  <= {sync[0], pin};
            press <= 1'b0;
            rel   <= 1'b0;
            lng   <= 1'b0;

            if (s == level) begin
                dcnt <= '0;
            end else if (accept) begin
                dcnt  <= '0;
                level <= s;
                press <= s;
                rel   <= ~s;
                if (s)
                    toggle <= ~toggle;
            end else begin
                dcnt <= dcnt + 1'b1;
            end

            // hcnt freezes once held is set; only an accepted release clears it
            if (accept && !s) begin
                held <= 1'b0;
                hcnt <= '0;
            end else if (!level) begin
                hcnt <= '0;
            end else if (!held) begin
                if (hcnt == HMAX) begin
                    lng  <= 1'b1;
                    held <= 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end
endmodule

module key_debounce_multi #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_toggle,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_held
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_debounce_multi_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin    (key_in[i]),
            .level  (key_level[i]),
            .press  (key_press[i]),
            .rel    (key_release[i]),
            .toggle (key_toggle[i]),
            .lng    (key_long[i]),
            .held   (key_held[i])
        );
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with short debounce/long-press timings.

module tb_key_debounce_multi;
    localparam int NK = 3;
    localparam int DC = 16;
    localparam int LC = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level, key_press, key_release, key_toggle, key_long, key_held;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int press_cnt [NK];
    int rel_cnt   [NK];
    int long_cnt  [NK];
    int press_cyc [NK];
    int long_cyc  [NK];
    int bp, br, bl;

    key_debounce_multi #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_toggle  (key_toggle),
        .key_long    (key_long),
        .key_held    (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
            press_cyc[i] = 0; long_cyc[i] = 0;
        end
    end

    // pulses are one cycle wide, so sampling on the falling edge counts each once
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NK; i++) begin
                if (key_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
                if (key_release[i]) rel_cnt[i]++;
                if (key_long[i])    begin long_cnt[i]++; long_cyc[i] = cyc; end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   32'(key_level),   0);
        chk({tag, "_press"},   32'(key_press),   0);
        chk({tag, "_release"}, 32'(key_release), 0);
        chk({tag, "_toggle"},  32'(key_toggle),  0);
        chk({tag, "_long"},    32'(key_long),    0);
        chk({tag, "_held"},    32'(key_held),    0);
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 3'b111;
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(5);
        chk_all_zero("idle");

        // 1: clean press on channel 0, accepted at edge DC+2
        key_in[0] = 1'b0;
        tick(DC + 1);
        chk("t1_level_early", 32'(key_level), 0);
        tick(1);
        chk("t1_level",   32'(key_level),   3'b001);
        chk("t1_press",   32'(key_press),   3'b001);
        chk("t1_toggle",  32'(key_toggle),  3'b001);
        chk("t1_release", 32'(key_release), 0);
        tick(1);
        chk("t1_press_one_cycle", 32'(key_press), 0);
        chk("t1_level_hold",      32'(key_level), 3'b001);
        key_in[0] = 1'b1;
        tick(DC + 2);
        chk("t1_release_pulse", 32'(key_release), 3'b001);
        chk("t1_level_rel",     32'(key_level),   0);
        tick(5);
        chk("t1_no_long", 32'(long_cnt[0]), 0);

        // 2: bounce shorter than the debounce window never gets accepted
        bp = press_cnt[1]; br = rel_cnt[1];
        for (int k = 0; k < 20; k++) begin
            key_in[1] = ~key_in[1];
            tick(5);
        end
        tick(30);
        chk("t2_press",   32'(press_cnt[1] - bp), 0);
        chk("t2_release", 32'(rel_cnt[1] - br),   0);
        chk("t2_level",   32'(key_level[1]),      0);

        // 3: two press/release cycles on channel 2
        bp = press_cnt[2]; br = rel_cnt[2]; bl = long_cnt[2];
        for (int r = 0; r < 2; r++) begin
            key_in[2] = 1'b0;
            tick(40);
            chk("t3_level_pressed", 32'(key_level[2]),  1);
            chk("t3_toggle",        32'(key_toggle[2]), (r == 0) ? 1 : 0);
            key_in[2] = 1'b1;
            tick(40);
            chk("t3_level_released", 32'(key_level[2]), 0);
        end
        chk("t3_press_cnt",   32'(press_cnt[2] - bp), 2);
        chk("t3_release_cnt", 32'(rel_cnt[2] - br),   2);
        chk("t3_long_cnt",    32'(long_cnt[2] - bl),  0);

        // 4: long press, glitch during hold, then release
        bl = long_cnt[0]; br = rel_cnt[0];
        key_in[0] = 1'b0;
        tick(200);
        chk("t4_long_cnt",   32'(long_cnt[0] - bl),           1);
        chk("t4_long_delay", 32'(long_cyc[0] - press_cyc[0]), LC);
        chk("t4_held",       32'(key_held[0]),                1);
        key_in[0] = 1'b1;
        tick(3);
        key_in[0] = 1'b0;
        tick(20);
        chk("t4_held_glitch", 32'(key_held[0]),      1);
        chk("t4_no_rel",      32'(rel_cnt[0] - br),  0);
        key_in[0] = 1'b1;
        tick(DC + 1);
        chk("t4_held_before_rel", 32'(key_held[0]),    1);
        chk("t4_rel_early",       32'(key_release[0]), 0);
        tick(1);
        chk("t4_release",   32'(key_release[0]), 1);
        chk("t4_held_clr",  32'(key_held[0]),    0);
        chk("t4_level_clr", 32'(key_level[0]),   0);
        tick(5);
        chk("t4_long_once", 32'(long_cnt[0] - bl), 1);

        // 5: simultaneous presses
        key_in = 3'b000;
        tick(DC + 2);
        chk("t5_press",  32'(key_press),  3'b111);
        chk("t5_toggle", 32'(key_toggle), 3'b111);
        tick(1);
        chk("t5_press_clr", 32'(key_press), 0);
        key_in = 3'b111;
        tick(25);
        chk("t5_level_rel", 32'(key_level), 0);

        // 6: reset 10 cycles into a debounce, pin still pressed afterwards
        key_in[0] = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        tick(2);
        rst_n = 1'b1;
        tick(DC + 1);
        chk("t6_level_early", 32'(key_level), 0);
        tick(1);
        chk("t6_press",  32'(key_press),  3'b001);
        chk("t6_level",  32'(key_level),  3'b001);
        chk("t6_toggle", 32'(key_toggle), 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
